// File: rtl/gmii_rx_to_fifo_if.sv
// gmii_rx_to_fifo_if
//   Write side of the RX->TX elastic FIFO.
//   master : the GMII receive stage (drives the write bus, sees almost_full)
//   slave  : the FIFO (accepts the write bus, reports almost_full)
//   fifo_we          write strobe, one entry per cycle when high
//   fifo_d           byte written
//   fifo_er          per-byte error flag written alongside fifo_d
//   fifo_frame_end   marks the last byte of a frame
//   fifo_almost_full FIFO has fewer than 2 free entries
interface gmii_rx_to_fifo_if;
    logic       fifo_we;
    logic [7:0] fifo_d;
    logic       fifo_er;
    logic       fifo_frame_end;
    logic       fifo_almost_full;

    modport master (
        output fifo_we,
        output fifo_d,
        output fifo_er,
        output fifo_frame_end,
        input  fifo_almost_full
    );

    modport slave (
        input  fifo_we,
        input  fifo_d,
        input  fifo_er,
        input  fifo_frame_end,
        output fifo_almost_full
    );
endinterface

// File: rtl/gmii_rx_to_fifo.sv
// gmii_rx_to_fifo
//   Moves GMII RX bytes into the RX->TX elastic FIFO, tagging each byte with
//   its error flag and marking the last byte of every frame. Every frame that
//   is started is always terminated with a frame-end entry, even when it is
//   truncated by FIFO back-pressure or by the length limit.
// Ports
//   clock        RX byte clock (GMII RX_CLK domain)
//   reset_n      synchronous, active-low reset
//   rx_dv        GMII receive data valid
//   rxd          GMII receive data
//   rx_er        GMII receive error (ignored while rx_dv=0)
//   fifo         FIFO write bus (master side)
//   frame_count  frames terminated normally (wraps)
//   drop_count   frames truncated or wholly dropped (wraps)
//   overflow     one-cycle pulse on each FIFO-caused truncation/drop
module gmii_rx_to_fifo #(
    parameter logic [15:0] MAX_FRAME_LEN = 16'd16383
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     rx_dv,
    input  logic [7:0]               rxd,
    input  logic                     rx_er,
    gmii_rx_to_fifo_if.master        fifo,
    output logic [15:0]              frame_count,
    output logic [15:0]              drop_count,
    output logic                     overflow
);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DROP
    } state_t;

    localparam logic [15:0] LAST_IDX = MAX_FRAME_LEN - 16'd1;

    state_t      state;
    logic [7:0]  hold_d;
    logic        hold_er;
    logic        hold_valid;
    logic [15:0] byte_count;

    // The one-byte hold register delays the stream so that rx_dv falling is
    // seen while the last byte is still in hand; it can then be written with
    // frame_end set.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state               <= IDLE;
            hold_d              <= '0;
            hold_er             <= 1'b0;
            hold_valid          <= 1'b0;
            byte_count          <= '0;
            fifo.fifo_we        <= 1'b0;
            fifo.fifo_d         <= '0;
            fifo.fifo_er        <= 1'b0;
            fifo.fifo_frame_end <= 1'b0;
            frame_count         <= '0;
            drop_count          <= '0;
            overflow            <= 1'b0;
        end else begin
            fifo.fifo_we        <= 1'b0;
            fifo.fifo_d         <= '0;
            fifo.fifo_er        <= 1'b0;
            fifo.fifo_frame_end <= 1'b0;
            overflow            <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (rx_dv) begin
                        if (!fifo.fifo_almost_full) begin
                            hold_d     <= rxd;
                            hold_er    <= rx_er;
                            hold_valid <= 1'b1;
                            byte_count <= '0;
                            state      <= RECV;
                        end else begin
                            drop_count <= drop_count + 16'd1;
                            overflow   <= 1'b1;
                            state      <= DROP;
                        end
                    end
                end

                RECV: begin
                    if (!hold_valid) begin
                        state <= IDLE;
                    end else if (!rx_dv) begin
                        // End of frame wins over back-pressure and length limit.
                        fifo.fifo_we        <= 1'b1;
                        fifo.fifo_d         <= hold_d;
                        fifo.fifo_er        <= hold_er;
                        fifo.fifo_frame_end <= 1'b1;
                        hold_valid          <= 1'b0;
                        byte_count          <= byte_count + 16'd1;
                        frame_count         <= frame_count + 16'd1;
                        state               <= IDLE;
                    end else if (fifo.fifo_almost_full || (byte_count == LAST_IDX)) begin
                        // Truncate: the held byte becomes an errored terminator.
                        // almost_full still leaves one free entry for it.
                        fifo.fifo_we        <= 1'b1;
                        fifo.fifo_d         <= hold_d;
                        fifo.fifo_er        <= 1'b1;
                        fifo.fifo_frame_end <= 1'b1;
                        hold_valid          <= 1'b0;
                        byte_count          <= byte_count + 16'd1;
                        drop_count          <= drop_count + 16'd1;
                        overflow            <= fifo.fifo_almost_full;
                        state               <= DROP;
                    end else begin
                        fifo.fifo_we <= 1'b1;
                        fifo.fifo_d  <= hold_d;
                        fifo.fifo_er <= hold_er;
                        hold_d       <= rxd;
                        hold_er      <= rx_er;
                        byte_count   <= byte_count + 16'd1;
                    end
                end

                DROP: begin
                    if (!rx_dv) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state      <= IDLE;
                    hold_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_rx_to_fifo.sv
// tb_gmii_rx_to_fifo
//   Directed bench for gmii_rx_to_fifo. Two instances share the same GMII
//   stimulus: dut0 with the default length limit and dut1 with
//   MAX_FRAME_LEN=16. Each FIFO write is captured at the falling edge and
//   compared against hand-derived expectations.
module tb_gmii_rx_to_fifo;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        rx_dv;
    logic [7:0]  rxd;
    logic        rx_er;
    logic        af;

    always #5 clock = ~clock;

    gmii_rx_to_fifo_if fif0 ();
    gmii_rx_to_fifo_if fif1 ();
    assign fif0.fifo_almost_full = af;
    assign fif1.fifo_almost_full = af;

    logic [15:0] fc0, dc0, fc1, dc1;
    logic        ovf0, ovf1;

    gmii_rx_to_fifo dut0 (
        .clock       (clock),
        .reset_n     (reset_n),
        .rx_dv       (rx_dv),
        .rxd         (rxd),
        .rx_er       (rx_er),
        .fifo        (fif0.master),
        .frame_count (fc0),
        .drop_count  (dc0),
        .overflow    (ovf0)
    );

    gmii_rx_to_fifo #(.MAX_FRAME_LEN(16'd16)) dut1 (
        .clock       (clock),
        .reset_n     (reset_n),
        .rx_dv       (rx_dv),
        .rxd         (rxd),
        .rx_er       (rx_er),
        .fifo        (fif1.master),
        .frame_count (fc1),
        .drop_count  (dc1),
        .overflow    (ovf1)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first_cyc = 0;
    int ovf0_n = 0;
    int ovf1_n = 0;
    int idle_bad = 0;
    logic [9:0] q0[$];
    logic [9:0] q1[$];
    int         wc0[$];
    logic [7:0] frame_data[0:63];

    always @(posedge clock) cyc <= cyc + 1;

    // Capture writes as {d, er, end}; outputs must be all-zero when idle.
    always @(negedge clock) begin
        if (fif0.fifo_we) begin
            q0.push_back({fif0.fifo_d, fif0.fifo_er, fif0.fifo_frame_end});
            wc0.push_back(cyc);
        end else if ({fif0.fifo_d, fif0.fifo_er, fif0.fifo_frame_end} != 10'd0) begin
            idle_bad++;
        end
        if (fif1.fifo_we) begin
            q1.push_back({fif1.fifo_d, fif1.fifo_er, fif1.fifo_frame_end});
        end else if ({fif1.fifo_d, fif1.fifo_er, fif1.fifo_frame_end} != 10'd0) begin
            idle_bad++;
        end
        if (ovf0) ovf0_n++;
        if (ovf1) ovf1_n++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 64; i++) frame_data[i] = 8'(i + 1);
    endtask

    // Byte i is driven just after edge i and sampled at edge i+1; almost_full
    // rises together with byte af_at and is left high for the caller to clear.
    task automatic drive_frame(input int len, input int er_at, input int af_at);
        for (int i = 0; i < len; i++) begin
            @(posedge clock);
            #1;
            if (i == 0) first_cyc = cyc;
            rx_dv = 1'b1;
            rxd   = frame_data[i];
            rx_er = (i == er_at);
            if (af_at >= 0 && i >= af_at) af = 1'b1;
        end
        @(posedge clock);
        #1;
        rx_dv = 1'b0;
        rxd   = 8'h00;
        rx_er = 1'b0;
    endtask

    task automatic check_writes(input string tag, input logic [9:0] q[$], input int n,
                                input int er_idx, input bit trunc);
        logic [9:0] e;
        check($sformatf("%s count", tag), q.size(), n);
        for (int i = 0; i < n && i < q.size(); i++) begin
            e = {frame_data[i], (i == er_idx) || (trunc && i == n - 1), i == n - 1};
            check($sformatf("%s[%0d]", tag, i), q[i], e);
        end
    endtask

    initial begin
        logic [9:0] e2[4];

        reset_n = 1'b0;
        rx_dv   = 1'b0;
        rxd     = 8'h00;
        rx_er   = 1'b0;
        af      = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst we",   fif0.fifo_we, 0);
        check("rst d",    fif0.fifo_d, 0);
        check("rst er",   fif0.fifo_er, 0);
        check("rst end",  fif0.fifo_frame_end, 0);
        check("rst ovf",  ovf0, 0);
        check("rst fc",   fc0, 0);
        check("rst dc",   dc0, 0);
        reset_n = 1'b1;
        idle(2);

        // Preamble + SFD
        for (int i = 0; i < 7; i++) frame_data[i] = 8'h55;
        frame_data[7] = 8'hD5;
        q0.delete(); wc0.delete();
        drive_frame(8, -1, -1);
        idle(3);
        check_writes("pre", q0, 8, -1, 0);
        if (wc0.size() == 8) begin
            check("pre latency", wc0[0] - first_cyc, 2);
            check("pre span", wc0[7] - wc0[0], 7);
        end
        check("pre fc", fc0, 1);
        check("pre dc", dc0, 0);

        // 1-byte frame, one idle cycle, 3-byte frame
        q0.delete(); wc0.delete();
        frame_data[0] = 8'hAB;
        drive_frame(1, -1, -1);
        frame_data[0] = 8'h01; frame_data[1] = 8'h02; frame_data[2] = 8'h03;
        drive_frame(3, -1, -1);
        idle(3);
        e2[0] = {8'hAB, 1'b0, 1'b1};
        e2[1] = {8'h01, 1'b0, 1'b0};
        e2[2] = {8'h02, 1'b0, 1'b0};
        e2[3] = {8'h03, 1'b0, 1'b1};
        check("b2b count", q0.size(), 4);
        for (int i = 0; i < 4 && i < q0.size(); i++) check($sformatf("b2b[%0d]", i), q0[i], e2[i]);
        if (wc0.size() == 4) begin
            check("b2b gap0", wc0[1] - wc0[0], 2);
            check("b2b gap1", wc0[3] - wc0[1], 2);
        end
        check("b2b fc", fc0, 3);

        // 64-byte frame with rx_er on byte 10
        fill_ramp();
        q0.delete();
        drive_frame(64, 9, -1);
        idle(3);
        check_writes("err", q0, 64, 9, 0);
        check("err fc", fc0, 4);
        check("err dc1", dc1, 1);

        // almost_full while byte 20 is held: 19 normal + errored terminator
        q0.delete(); ovf0_n = 0; ovf1_n = 0;
        drive_frame(64, -1, 20);
        idle(2);
        af = 1'b0;
        idle(1);
        check_writes("af", q0, 20, -1, 1);
        check("af ovf pulses", ovf0_n, 1);
        check("af dc", dc0, 1);
        check("af fc", fc0, 4);
        check("af len-trunc ovf1", ovf1_n, 0);
        check("af dc1", dc1, 2);

        // length limit on dut1 (MAX_FRAME_LEN=16)
        q1.delete(); ovf1_n = 0;
        drive_frame(20, -1, -1);
        idle(3);
        check_writes("max20", q1, 16, -1, 1);
        check("max20 dc1", dc1, 3);
        check("max20 ovf1", ovf1_n, 0);
        q1.delete();
        drive_frame(16, -1, -1);
        idle(3);
        check_writes("max16", q1, 16, -1, 0);
        check("max16 fc1", fc1, 4);
        check("max16 dc1", dc1, 3);
        check("fc0 after max", fc0, 6);

        // frame start while almost full: wholly dropped
        q0.delete(); q1.delete(); ovf0_n = 0; ovf1_n = 0;
        af = 1'b1;
        drive_frame(5, -1, -1);
        idle(2);
        af = 1'b0;
        idle(1);
        check("afstart q0", q0.size(), 0);
        check("afstart q1", q1.size(), 0);
        check("afstart dc0", dc0, 2);
        check("afstart dc1", dc1, 4);
        check("afstart ovf0", ovf0_n, 1);
        check("afstart ovf1", ovf1_n, 1);

        // reset in the middle of a frame
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            rx_dv = 1'b1;
            rxd   = frame_data[i];
        end
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        check("mrst we",  fif0.fifo_we, 0);
        check("mrst d",   fif0.fifo_d, 0);
        check("mrst end", fif0.fifo_frame_end, 0);
        check("mrst fc",  fc0, 0);
        check("mrst dc",  dc0, 0);
        check("mrst we1", fif1.fifo_we, 0);
        rx_dv   = 1'b0;
        rxd     = 8'h00;
        reset_n = 1'b1;
        idle(2);
        q0.delete();
        fill_ramp();
        drive_frame(2, -1, -1);
        idle(3);
        check_writes("postrst", q0, 2, -1, 0);
        check("postrst fc", fc0, 1);

        check("idle outputs zero", idle_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
